// File: rtl/dac_pkg.sv
`default_nettype none
// ============================================================================
// Package  : dac_pkg
// Brief    : Shared state encoding and constants for the DAC sample player.
// Revision : 1.0 - initial release
// ============================================================================
package dac_pkg;

  localparam int ACC_W = 32;
  localparam logic [7:0] DAC_MIDSCALE = 8'h80;

  typedef logic [1:0] dac_state_t;
  localparam dac_state_t ST_IDLE    = 2'd0;
  localparam dac_state_t ST_PREFILL = 2'd1;
  localparam dac_state_t ST_PLAY    = 2'd2;

endpackage
`default_nettype wire

// File: rtl/dda_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : dda_tick_gen
// Brief    : Division-free sample-rate tick generator (clamped step + DDA).
// Revision : 1.0 - initial release
// ============================================================================
module dda_tick_gen
  import dac_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int FREQ_UNIT_HZ = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [12:0] freq,
  output logic        o_tick
);

  // Clamping at a quarter of the clock keeps ticks at least 4 cycles apart.
  localparam logic [39:0]      c_STEP_MAX = 40'(CLK_HZ / 4);
  localparam logic [ACC_W-1:0] c_CLK      = ACC_W'(CLK_HZ);

  logic [39:0]      w_prod;
  logic [ACC_W-1:0] w_step_clamped;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W-1:0] r_step;
  logic [ACC_W-1:0] r_acc;
  logic             r_tick;

  assign w_prod         = 40'(freq) * 40'(FREQ_UNIT_HZ);
  assign w_step_clamped = (w_prod > c_STEP_MAX) ? ACC_W'(c_STEP_MAX) : ACC_W'(w_prod);
  assign w_sum          = {1'b0, r_acc} + {1'b0, r_step};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step <= '0;
    end else begin
      r_step <= w_step_clamped;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_tick <= 1'b0;
    end else if (!run) begin
      r_acc  <= '0;
      r_tick <= 1'b0;
    end else if (w_sum >= {1'b0, c_CLK}) begin
      r_acc  <= ACC_W'(w_sum - {1'b0, c_CLK});
      r_tick <= 1'b1;
    end else begin
      r_acc  <= w_sum[ACC_W-1:0];
      r_tick <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/dac_sample_player.sv
`default_nettype none
// ============================================================================
// Module   : dac_sample_player
// Brief    : Paces waveform FIFO reads at the programmed sample rate and
//            drives an 8-bit parallel DAC with a rising-edge latch clock.
// Options  : DAC_MIDSCALE_IDLE_EN - park the DAC at mid-scale in IDLE/PREFILL
// Revision : 1.0 - initial release
// ============================================================================
module dac_sample_player
  import dac_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int FREQ_UNIT_HZ = 1000,
  parameter int START_LVL    = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        play_en,
  input  logic [12:0] freq,
  input  logic [7:0]  fifo_dout,
  input  logic        fifo_empty,
  input  logic [12:0] fifo_level,
  output logic        fifo_rd_en,
  output logic [7:0]  dac_data,
  output logic        dac_clk,
  output logic        playing,
  output logic [15:0] underrun_cnt
);

  localparam logic [12:0] c_START_LVL = 13'(START_LVL);

  dac_state_t  r_state;
  dac_state_t  w_state_nxt;
  logic        w_tick;
  logic        w_stop;
  logic        w_run;
  logic        w_rd_en;
  logic        w_underrun;
  logic        r_rd_d;
  logic [7:0]  r_dac_data;
  logic        r_dac_clk;
  logic        r_playing;
  logic [15:0] r_underrun_cnt;

  dda_tick_gen #(
    .CLK_HZ       (CLK_HZ),
    .FREQ_UNIT_HZ (FREQ_UNIT_HZ)
  ) u_dda_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (w_run),
    .freq   (freq),
    .o_tick (w_tick)
  );

  // Stop is taken straight from the inputs so it beats a coincident tick.
  assign w_stop     = !play_en || (freq == '0);
  assign w_run      = (r_state == ST_PLAY);
  assign w_rd_en    = w_run && w_tick && !fifo_empty && !w_stop;
  assign w_underrun = w_run && w_tick && fifo_empty && !w_stop;

  always_comb begin
    w_state_nxt = r_state;
    if (w_stop) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    w_state_nxt = ST_PREFILL;
        ST_PREFILL: if (fifo_level >= c_START_LVL) w_state_nxt = ST_PLAY;
        ST_PLAY:    if (w_underrun) w_state_nxt = ST_PREFILL;
        default:    w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_playing      <= 1'b0;
      r_underrun_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_playing <= (w_state_nxt == ST_PLAY);
      if (w_underrun && (r_underrun_cnt != 16'hFFFF)) begin
        r_underrun_cnt <= r_underrun_cnt + 16'd1;
      end
    end
  end

`ifdef DAC_MIDSCALE_IDLE_EN
  logic w_park;
  logic r_park_pend;

  // A park waits for any in-flight sample and for dac_clk to be high again,
  // so every latch clock low pulse is followed by its own rising edge.
  assign w_park = (w_state_nxt != r_state) && (w_state_nxt != ST_PLAY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_d      <= 1'b0;
      r_dac_data  <= DAC_MIDSCALE;
      r_dac_clk   <= 1'b1;
      r_park_pend <= 1'b0;
    end else begin
      r_rd_d <= w_rd_en;
      if (r_rd_d) begin
        r_dac_data <= fifo_dout;
        r_dac_clk  <= 1'b0;
      end else if (r_park_pend && r_dac_clk) begin
        r_dac_data <= DAC_MIDSCALE;
        r_dac_clk  <= 1'b0;
      end else begin
        r_dac_clk  <= 1'b1;
      end
      if (w_park) begin
        r_park_pend <= 1'b1;
      end else if (!r_rd_d && r_dac_clk) begin
        r_park_pend <= 1'b0;
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_d     <= 1'b0;
      r_dac_data <= DAC_MIDSCALE;
      r_dac_clk  <= 1'b1;
    end else begin
      r_rd_d    <= w_rd_en;
      r_dac_clk <= !r_rd_d;
      if (r_rd_d) begin
        r_dac_data <= fifo_dout;
      end
    end
  end
`endif

  assign fifo_rd_en   = w_rd_en;
  assign dac_data     = r_dac_data;
  assign dac_clk      = r_dac_clk;
  assign playing      = r_playing;
  assign underrun_cnt = r_underrun_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dac_sample_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_sample_player
// Brief    : Self-checking bench for dac_sample_player with a FIFO stand-in
//            and a phase-based reference model of the playback rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dac_sample_player;

  localparam int CLK_HZ    = 50_000_000;
  localparam int UNIT_HZ   = 1000;
  localparam int START_LVL = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        play_en = 1'b0;
  logic [12:0] freq = '0;
  logic [7:0]  fifo_dout = '0;
  logic        fifo_empty = 1'b1;
  logic [12:0] fifo_level = '0;
  logic        fifo_rd_en;
  logic [7:0]  dac_data;
  logic        dac_clk;
  logic        playing;
  logic [15:0] underrun_cnt;

  logic        c_en = 1'b0;
  logic        c_rd;
  logic [7:0]  c_data;
  logic        c_dclk;
  logic        c_play;
  logic [15:0] c_ur;

  always #5 clk = ~clk;

  dac_sample_player #(.CLK_HZ(CLK_HZ), .FREQ_UNIT_HZ(UNIT_HZ), .START_LVL(START_LVL)) u_dut (
    .clk(clk), .rst_n(rst_n), .play_en(play_en), .freq(freq), .fifo_dout(fifo_dout),
    .fifo_empty(fifo_empty), .fifo_level(fifo_level), .fifo_rd_en(fifo_rd_en),
    .dac_data(dac_data), .dac_clk(dac_clk), .playing(playing), .underrun_cnt(underrun_cnt)
  );

  // Coarser frequency unit so that the maximum freq code hits the step clamp.
  dac_sample_player #(.CLK_HZ(CLK_HZ), .FREQ_UNIT_HZ(10_000), .START_LVL(START_LVL)) u_clamp (
    .clk(clk), .rst_n(rst_n), .play_en(c_en), .freq(13'd8191), .fifo_dout(8'h5A),
    .fifo_empty(1'b0), .fifo_level(13'd100), .fifo_rd_en(c_rd),
    .dac_data(c_data), .dac_clk(c_dclk), .playing(c_play), .underrun_cnt(c_ur)
  );

  typedef struct { int fr; int gmin; int gmax; } rate_vec_t;
  rate_vec_t vecs[5];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  byte unsigned q[$];
  byte unsigned stage[$];
  logic        d_pe = 1'b0;
  logic [12:0] d_fr = '0;
  logic        p_pe, p_empty, p_rd;
  logic [12:0] p_fr, p_level;

  int          m_mode;
  longint      m_phase, m_ticks, m_step;
  bit          m_tick;
  logic [7:0]  m_data;
  int          m_ur;
  int          due_cyc[$];
  byte unsigned due_val[$];

  int rd_count, last_rd_cyc, last_gap, gap_min, gap_max;
  int c_cnt, c_last, c_gmin, c_gmax;
  bit stop_on_tick, stop_hit;
  logic [7:0] last_sample;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint step_of(input logic [12:0] f);
    longint s;
    s = longint'(f) * UNIT_HZ;
    if (s > CLK_HZ / 4) s = CLK_HZ / 4;
    return s;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_phase = 0; m_ticks = 0; m_step = 0; m_tick = 0;
    m_data = 8'h80; m_ur = 0;
    due_cyc.delete(); due_val.delete();
    p_pe = 0; p_fr = 0; p_empty = 1; p_level = 0; p_rd = 0;
  endtask

  // Mode 0 = stopped, 1 = waiting for fill, 2 = playing. Sample n is due once
  // the summed phase since playback start reaches n full clock periods.
  task automatic cycle();
    bit   stop, exp_rd, old_tick;
    int   nmode;
    logic exp_clk;
    @(negedge clk);
    cyc++;
    stop = !p_pe || (p_fr == 0);
    old_tick = m_tick;
    nmode = m_mode;
    if (stop) nmode = 0;
    else if (m_mode == 0) nmode = 1;
    else if (m_mode == 1 && p_level >= START_LVL) nmode = 2;
    else if (m_mode == 2 && old_tick && p_empty) begin
      nmode = 1;
      if (m_ur < 65535) m_ur++;
    end
    if (m_mode == 2) begin
      m_phase += m_step;
      if (m_phase >= (m_ticks + 1) * CLK_HZ) begin m_ticks++; m_tick = 1; end
      else m_tick = 0;
    end else begin
      m_phase = 0; m_ticks = 0; m_tick = 0;
    end
    m_mode = nmode;
    m_step = step_of(p_fr);

    if (p_rd) begin
      fifo_dout = q.pop_front();
      last_sample = fifo_dout;
    end
    while (stage.size() > 0) q.push_back(stage.pop_front());
    if (stop_on_tick && m_tick && m_mode == 2) begin
      d_pe = 0; stop_on_tick = 0; stop_hit = 1;
    end
    play_en = d_pe;
    freq = d_fr;
    fifo_level = 13'(q.size());
    fifo_empty = (q.size() == 0);
    #1;
    exp_rd = (m_mode == 2) && m_tick && !fifo_empty && play_en && (freq != 0);
    exp_clk = 1'b1;
    if (due_cyc.size() > 0 && due_cyc[0] == cyc) begin
      void'(due_cyc.pop_front());
      m_data = due_val.pop_front();
      exp_clk = 1'b0;
    end
    chk("rd_en", fifo_rd_en, exp_rd);
    chk("playing", playing, m_mode == 2);
    chk("underrun_cnt", underrun_cnt, m_ur);
`ifndef DAC_MIDSCALE_IDLE_EN
    chk("dac_data", dac_data, m_data);
    chk("dac_clk", dac_clk, exp_clk);
`endif
    if (exp_rd) begin
      due_cyc.push_back(cyc + 2);
      due_val.push_back(q[0]);
    end
    p_rd = (fifo_rd_en === 1'b1);
    if (p_rd) begin
      if (rd_count > 0) begin
        last_gap = cyc - last_rd_cyc;
        if (last_gap < gap_min) gap_min = last_gap;
        if (last_gap > gap_max) gap_max = last_gap;
      end
      last_rd_cyc = cyc;
      rd_count++;
    end
    if (c_rd === 1'b1) begin
      if (c_cnt > 0) begin
        if (cyc - c_last < c_gmin) c_gmin = cyc - c_last;
        if (cyc - c_last > c_gmax) c_gmax = cyc - c_last;
      end
      c_last = cyc;
      c_cnt++;
    end
    p_pe = play_en; p_fr = freq; p_empty = fifo_empty; p_level = fifo_level;
  endtask

  task automatic clear_stats();
    rd_count = 0; gap_min = 1_000_000; gap_max = 0; last_gap = 0;
  endtask

  // Reset is asserted between clock edges and checked before the next edge.
  task automatic hard_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst dac_data", dac_data, 8'h80);
    chk("rst dac_clk", dac_clk, 1'b1);
    chk("rst rd_en", fifo_rd_en, 1'b0);
    chk("rst underrun", underrun_cnt, 0);
    chk("rst playing", playing, 1'b0);
    q.delete(); stage.delete();
    d_pe = 0; d_fr = 0;
    play_en = 0; freq = 0; fifo_level = 0; fifo_empty = 1;
    model_reset();
    clear_stats();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    vecs[0] = '{1000, 50, 50};
    vecs[1] = '{500, 100, 100};
    vecs[2] = '{2000, 25, 25};
    vecs[3] = '{5000, 10, 10};
    vecs[4] = '{8191, 6, 7};
    stop_on_tick = 0; stop_hit = 0; last_sample = 8'h80;
    c_cnt = 0; c_last = 0; c_gmin = 1_000_000; c_gmax = 0;
    model_reset();
    hard_reset();

    foreach (vecs[r]) begin
      hard_reset();
      for (int i = 0; i < 30; i++) stage.push_back(8'(i));
      d_pe = 1; d_fr = 13'(vecs[r].fr);
      n = 0;
      while (rd_count < 12 && n < 2000) begin cycle(); n++; end
      chk($sformatf("reads@%0d", vecs[r].fr), rd_count >= 12, 1);
      chk($sformatf("gap_min@%0d", vecs[r].fr), gap_min, vecs[r].gmin);
      chk($sformatf("gap_max@%0d", vecs[r].fr), gap_max, vecs[r].gmax);
    end

    c_en = 1'b1;
    for (int i = 0; i < 80; i++) cycle();
    c_en = 1'b0;
    chk("clamp reads", c_cnt >= 15, 1);
    chk("clamp gap_min", c_gmin, 4);
    chk("clamp gap_max", c_gmax, 4);

    // One byte short of the start level must not start playback.
    hard_reset();
    for (int i = 0; i < 9; i++) stage.push_back(8'(i));
    d_pe = 1; d_fr = 13'd1000;
    for (int i = 0; i < 60; i++) cycle();
    chk("prefill below lvl", playing, 1'b0);
    stage.push_back(8'd9);
    n = 0;
    while (m_mode != 2 && n < 10) begin cycle(); n++; end
    cycle();
    chk("prefill at lvl", playing, 1'b1);

    stage.push_back(8'd10); stage.push_back(8'd11);
    n = 0;
    while (m_ur == 0 && n < 2000) begin cycle(); n++; end
    chk("underrun reads", rd_count, 12);
    chk("underrun cnt", underrun_cnt, 1);
    chk("underrun playing", playing, 1'b0);
    for (int i = 0; i < 5; i++) cycle();
`ifdef DAC_MIDSCALE_IDLE_EN
    chk("underrun park", dac_data, 8'h80);
`else
    chk("underrun hold", dac_data, 8'd11);
`endif
    for (int i = 0; i < 10; i++) stage.push_back(8'(20 + i));
    n = 0;
    while (m_mode != 2 && n < 20) begin cycle(); n++; end
    cycle();
    chk("refill playing", playing, 1'b1);
    for (int i = 0; i < 120; i++) cycle();
    hard_reset();

    hard_reset();
    for (int i = 0; i < 20; i++) stage.push_back(8'(8'h40 + i));
    d_pe = 1; d_fr = 13'd1000;
    for (int i = 0; i < 120; i++) cycle();
    stop_on_tick = 1; stop_hit = 0;
    n = 0;
    while (!stop_hit && n < 200) begin cycle(); n++; end
    chk("stop on tick seen", stop_hit, 1);
    chk("stop no read", fifo_rd_en, 1'b0);
    cycle();
    chk("stop idle", playing, 1'b0);
    for (int i = 0; i < 4; i++) cycle();
`ifdef DAC_MIDSCALE_IDLE_EN
    chk("stop park", dac_data, 8'h80);
`else
    chk("stop hold", dac_data, last_sample);
`endif

    hard_reset();
    for (int i = 0; i < 40; i++) stage.push_back(8'(i));
    d_pe = 1; d_fr = 13'd1000;
    n = 0;
    while (rd_count < 4 && n < 1000) begin cycle(); n++; end
    for (int i = 0; i < 20; i++) cycle();
    d_fr = 13'd500;
    n = rd_count;
    while (rd_count == n && rd_count < 100) cycle();
    chk("rate trans gap", (last_gap >= 50) && (last_gap <= 101), 1);
    clear_stats();
    n = 0;
    while (rd_count < 5 && n < 1000) begin cycle(); n++; end
    chk("rate new gap_min", gap_min, 100);
    chk("rate new gap_max", gap_max, 100);

    hard_reset();
    d_pe = 1; d_fr = 13'd1000;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 14) == 0) stage.push_back(8'($urandom));
      if (i % 500 == 0) d_fr = 13'($urandom_range(200, 8191));
      if ($urandom_range(0, 799) == 0) d_fr = 0;
      else if (d_fr == 0 && $urandom_range(0, 19) == 0) d_fr = 13'd3000;
      if ($urandom_range(0, 599) == 0) d_pe = ~d_pe;
      else if (!d_pe && $urandom_range(0, 19) == 0) d_pe = 1;
      cycle();
    end
    hard_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
